// File: rtl/ast_mldfifo.sv
// ast_mldfifo: flop-based FIFO with an explicit occupancy counter, bulk
// parallel load, pop-recirculation, occupancy flags and sticky error flags.
// data_out is registered and is paired with a one-cycle data_valid strobe.
module ast_mldfifo #(
  parameter int DEPTH     = 8,
  parameter int DATAWIDTH = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic                                push,
  input  logic                                pop,
  input  logic                                recirc,
  input  logic                                parallel_load,
  input  logic [CW-1:0]                       load_count,
  input  logic [DEPTH-1:0][DATAWIDTH-1:0]     array_in,
  input  logic [DATAWIDTH-1:0]                data_in,
  output logic [DATAWIDTH-1:0]                data_out,
  output logic                                data_valid,
  output logic [CW-1:0]                       count,
  output logic                                empty,
  output logic                                full,
  output logic                                almost_empty,
  output logic                                almost_full,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int PW = $clog2(DEPTH);

  // Storage: plain flops, contents are never reset.
  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  // Control state.
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        cnt_q,  cnt_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d;
  logic                 dv_q,   dv_d;
  logic                 ovf_q,  ovf_d;
  logic                 udf_q,  udf_d;

  // Storage write controls produced by the command decode.
  logic                 wr_en;
  logic [PW-1:0]        wr_addr;
  logic [DATAWIDTH-1:0] wr_data;
  logic                 bulk_en;

  logic                 is_empty;
  logic                 is_full;
  logic                 pop_ok;
  logic                 push_ok;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CW'(DEPTH));

  // Command decode: clr beats parallel_load, which beats push/pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    wr_en   = 1'b0;
    wr_addr = wptr_q;
    wr_data = data_in;
    bulk_en = 1'b0;
    pop_ok  = 1'b0;
    push_ok = 1'b0;

    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      dout_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else if (parallel_load) begin
      // Whole array is written; only the first min(load_count, DEPTH) count.
      bulk_en = 1'b1;
      rptr_d  = '0;
      cnt_d   = (load_count > CW'(DEPTH)) ? CW'(DEPTH) : load_count;
      // DEPTH is a power of two, so the low bits give count mod DEPTH.
      wptr_d  = cnt_d[PW-1:0];
    end else begin
      pop_ok  = pop && !is_empty;
      // A recirculating pop owns the write port, so push is ignored then.
      // A pop in the same cycle frees the slot a full FIFO needs.
      push_ok = push && !(pop_ok && recirc) && (!is_full || pop_ok);

      if (pop && is_empty) begin
        udf_d = 1'b1;
      end
      if (push && is_full && !pop_ok) begin
        ovf_d = 1'b1;
      end

      if (pop_ok) begin
        // Read happens before this edge's write, so a full push+pop
        // still returns the old head.
        dout_d = mem_q[rptr_q];
        dv_d   = 1'b1;
        rptr_d = rptr_q + PW'(1);
      end

      if (pop_ok && recirc) begin
        wr_en   = 1'b1;
        wr_data = mem_q[rptr_q];
        wptr_d  = wptr_q + PW'(1);
      end else if (push_ok) begin
        wr_en   = 1'b1;
        wr_data = data_in;
        wptr_d  = wptr_q + PW'(1);
      end

      if (push_ok && !pop_ok) begin
        cnt_d = cnt_q + CW'(1);
      end else if (pop_ok && !push_ok && !recirc) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage writes; suppressed while reset is held so no command lands.
  always_ff @(posedge clk) begin
    if (rst && bulk_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= array_in[i];
      end
    end else if (rst && wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Outputs and flags decoded from registered state.
  always_comb begin
    data_out     = dout_q;
    data_valid   = dv_q;
    count        = cnt_q;
    empty        = is_empty;
    full         = is_full;
    almost_empty = (int'(cnt_q) <= AE_THRESH);
    almost_full  = (int'(cnt_q) >= AF_THRESH);
    overflow     = ovf_q;
    underflow    = udf_q;
  end

endmodule

// File: doc/ast_mldfifo.md
AST_MLDFIFO -- requirements
Module: ast_mldfifo

Interface
REQ-001 Parameter DEPTH, default 8: number of entries; SHALL be a power of 2, at least 2.
REQ-002 Parameter DATAWIDTH, default 8: bits per entry.
REQ-003 Parameter AF_THRESH, default DEPTH-1: almost_full asserts when count >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 1: almost_empty asserts when count <= AE_THRESH.
REQ-005 Ports SHALL be exactly as listed; CW = $clog2(DEPTH+1).
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- clr  in  1  synchronous soft clear of pointers, count and flags.
- push  in  1  write request.
- pop  in  1  read request.
- recirc  in  1  re-enqueue each popped word at the tail.
- parallel_load  in  1  bulk load from array_in.
- load_count  in  CW  number of valid words in the bulk load.
- array_in  in  DEPTH x DATAWIDTH  bulk load data; element 0 is the head.
- data_in  in  DATAWIDTH  push data.
- data_out  out  DATAWIDTH  registered popped word.
- data_valid  out  1  one-cycle strobe: data_out was updated this cycle.
- count  out  CW  current occupancy, 0..DEPTH.
- empty, full, almost_empty, almost_full  out  1 each  occupancy flags.
- overflow, underflow  out  1 each  sticky error flags.

Function
REQ-006 Command priority per cycle SHALL be: rst, then clr, then parallel_load, then push/pop.
REQ-007 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-008 Occupancy SHALL be tracked by an explicit count register, so full and empty are distinguishable when the pointers are equal.
REQ-009 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH); both are decoded from the registered count.
REQ-010 almost_full and almost_empty SHALL be decoded from the registered count using AF_THRESH and AE_THRESH.
REQ-011 clr SHALL do the following next edge: pointers 0, count 0, data_valid 0, data_out 0, overflow 0, underflow 0; storage is not altered.
REQ-012 parallel_load SHALL do the following:
- write all DEPTH entries from array_in;
- read pointer := 0; count := min(load_count, DEPTH); write pointer := count mod DEPTH;
- ignore push and pop that cycle; data_valid := 0.
REQ-013 An accepted push SHALL write data_in at the write pointer, advance the write pointer and increment count.
REQ-014 Pop on a non-empty FIFO SHALL, on the next edge:
- load data_out from the read pointer;
- pulse data_valid for exactly 1 cycle;
- advance the read pointer and decrement count.
- Latency is 1 cycle; data_out holds its value otherwise.
REQ-015 Push while full without a pop SHALL be dropped: storage and count unchanged, overflow set.
REQ-016 Pop while empty SHALL be dropped: data_out unchanged, data_valid 0, underflow set.
REQ-017 Simultaneous push and pop, FIFO neither empty nor full: both accepted, count unchanged.
REQ-018 Simultaneous push and pop while full:
- both accepted; count stays DEPTH; no overflow;
- data_out receives the pre-write (old) head word.
REQ-019 Simultaneous push and pop while empty:
- push accepted, count becomes 1;
- pop dropped with underflow set; no fall-through to data_out.
REQ-020 recirc=1 with an accepted pop:
- the popped word is written at the write pointer and the write pointer advances;
- count is unchanged;
- push is ignored that cycle and does not set overflow.
REQ-021 overflow and underflow SHALL stay set until rst or clr.
REQ-022 Storage SHALL be flops with no reset requirement on contents.

Reset
REQ-023 rst low SHALL asynchronously force:
- pointers 0, count 0, data_out 0, data_valid 0;
- empty 1, full 0, overflow 0, underflow 0;
- almost_empty 1 if AE_THRESH >= 0, almost_full 0.
REQ-024 Reset deassertion SHALL be synchronised externally; the block's first active edge follows rst high.
REQ-025 Reset asserted mid-transfer SHALL discard all in-flight commands; no partial pointer update is permitted.

Verification (DEPTH=4, DATAWIDTH=8)
REQ-026 Push 0x11, 0x22, 0x33, 0x44, then a fifth push of 0x55.
- full=1 and count=4 after the fourth push;
- the fifth push sets overflow=1; a following pop yields 0x11.
REQ-027 Pop while empty: underflow=1, data_valid=0, data_out unchanged; clr then clears underflow.
REQ-028 parallel_load with load_count=3 and array_in={A0,A1,A2,A3}:
- count=3, write pointer=3;
- three pops yield A0, A1, A2 with data_valid on each; empty=1 afterwards.
REQ-029 Full FIFO holding 1, 2, 3, 4; push 5 and pop in the same cycle:
- data_out=1, count=4, overflow=0;
- the next four pops yield 2, 3, 4, 5.
REQ-030 Hold recirc=1 and pop for 8 cycles on a FIFO loaded with 1, 2, 3, 4: data_out sequence 1,2,3,4,1,2,3,4; count stays 4 throughout.
REQ-031 Assert rst low asynchronously between clock edges with count=2: all outputs reach their reset values before the next clk edge.
